nios_system_irq_ctrl: RTL and testbench

Edge-capturing interrupt controller on the Nios system Avalon-MM bus, directly downstream of the interval timer and the other peripheral interrupt outputs. It latches rising edges of up to 16 same-clock interrupt sources into sticky pending bits and masks them. It presents a single registered `irq` to the CPU plus a lowest-index priority encoding. Software accesses it through a 16-bit, 3-bit-address register slave with the same read/write timing as the other system peripherals.

---
 rtl/nios_system_irq_ctrl_if.sv | 19 +
 rtl/nios_system_irq_ctrl.sv | 89 ++++++++
 tb/tb_nios_system_irq_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/nios_system_irq_ctrl_if.sv
// Avalon-MM register slave bus for the Nios system interrupt controller:
// 3-bit address, 16-bit data, active-low write strobe, registered read data.
interface nios_system_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_system_irq_ctrl.sv
// Edge-capturing interrupt controller with sticky pending bits, mask and priority encode.
// Optional irq coalescing hold-off is enabled by NIOS_SYSTEM_IRQ_CTRL_COALESCE_EN.
module nios_system_irq_ctrl #(
  parameter int unsigned N_SRC   = 8,
  parameter logic [15:0] HOLDOFF = 16'd50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios_system_irq_ctrl_if.slave bus,
  input  logic [N_SRC-1:0]     irq_in,
  output logic                 irq
);

  localparam logic [15:0] Valid = 16'((17'd1 << N_SRC) - 17'd1);

  logic [15:0] in_ext, in_d, pending, mask;
  logic [15:0] evt, w1c, frc, status, active, rd_next;
  logic [15:0] pending_next, mask_next;
  logic [3:0]  act_idx;
  logic        wr_en, irq_next;
  logic [15:0] holdcnt, holdcnt_next;

  assign in_ext = 16'(irq_in);
  assign evt    = in_ext & ~in_d;
  assign wr_en  = bus.chipselect && !bus.write_n;
  assign w1c    = (wr_en && bus.address == 3'd0) ? (bus.writedata & Valid) : 16'd0;
  assign frc    = (wr_en && bus.address == 3'd4) ? (bus.writedata & Valid) : 16'd0;
  assign status = pending & mask;

  // Set terms are OR'd after the clear so a same-cycle event beats W1C.
  assign pending_next = (pending & ~w1c) | evt | frc;
  assign mask_next    = (wr_en && bus.address == 3'd1) ? (bus.writedata & Valid) : mask;

  always_comb begin
    act_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (status[i]) act_idx = 4'(i);
    end
  end

  assign active = {|status, 11'd0, act_idx};

`ifdef NIOS_SYSTEM_IRQ_CTRL_COALESCE_EN
  always_comb begin
    holdcnt_next = holdcnt;
    irq_next     = |status;
    if (holdcnt != 16'd0) begin
      holdcnt_next = holdcnt - 16'd1;
      irq_next     = 1'b0;
    end
    // Registered irq falling: start the hold-off window.
    if (irq && !irq_next) holdcnt_next = HOLDOFF;
  end
`else
  assign holdcnt_next = 16'd0;
  assign irq_next     = |status;
`endif

  always_comb begin
    rd_next = 16'd0;
    unique case (bus.address)
      3'd0:    rd_next = pending;
      3'd1:    rd_next = mask;
      3'd2:    rd_next = status;
      3'd3:    rd_next = active;
      3'd5:    rd_next = holdcnt;
      default: rd_next = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_d         <= 16'd0;
      pending      <= 16'd0;
      mask         <= 16'd0;
      irq          <= 1'b0;
      bus.readdata <= 16'd0;
      holdcnt      <= 16'd0;
    end else begin
      in_d         <= in_ext;
      pending      <= pending_next;
      mask         <= mask_next;
      irq          <= irq_next;
      bus.readdata <= rd_next;
      holdcnt      <= holdcnt_next;
    end
  end

endmodule

// File: tb/tb_nios_system_irq_ctrl.sv
// Directed self-checking bench for nios_system_irq_ctrl (N_SRC=8, HOLDOFF=10).
module tb_nios_system_irq_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq_in = 8'd0;
  logic       irq;
  int         n_checks = 0;
  int         n_err = 0;
  logic [15:0] rv;

  nios_system_irq_ctrl_if bus ();

  nios_system_irq_ctrl #(
    .N_SRC   (8),
    .HOLDOFF (16'd10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    step();
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 16'd0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus.address = a; bus.chipselect = 1'b1;
    step();
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  initial begin
    bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 16'd0;
    step(); step();
    chk("rst_irq", {15'd0, irq}, 16'd0);
    chk("rst_readdata", bus.readdata, 16'd0);
    reset_n = 1'b1;
    step();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rv);
      chk($sformatf("rst_read_a%0d", a), rv, 16'd0);
    end
    chk("rst_irq_after", {15'd0, irq}, 16'd0);

    // Timer pulse on source 0
    wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    step();
    irq_in[0] = 1'b0;
    chk("tmr_irq_lat", {15'd0, irq}, 16'd0);
    step();
    chk("tmr_irq", {15'd0, irq}, 16'd1);
    rd(3'd0, rv); chk("tmr_pending", rv, 16'h0001);
    rd(3'd3, rv); chk("tmr_active", rv, 16'h8000);
    wr(3'd0, 16'h0001);
    chk("tmr_w1c_irq_hold", {15'd0, irq}, 16'd1);
    step();
    chk("tmr_w1c_irq", {15'd0, irq}, 16'd0);

    // Sources 2 and 5 together, priority encode
    wr(3'd1, 16'h0024);
    irq_in = 8'h24;
    step();
    irq_in = 8'h00;
    step();
    rd(3'd2, rv); chk("s25_status", rv, 16'h0024);
    rd(3'd3, rv); chk("s25_active", rv, 16'h8002);
    wr(3'd0, 16'h0004);
    rd(3'd3, rv); chk("s25_active_5", rv, 16'h8005);
    chk("s25_irq_still", {15'd0, irq}, 16'd1);
    wr(3'd0, 16'h0020);
    chk("s25_irq_lat", {15'd0, irq}, 16'd1);
    step();
    chk("s25_irq_off", {15'd0, irq}, 16'd0);

    // Event on source 3 in same cycle as W1C of bit 3: set wins
    irq_in[3] = 1'b1;
    step();
    irq_in[3] = 1'b0;
    step();
    irq_in[3] = 1'b1;
    wr(3'd0, 16'h0008);
    irq_in[3] = 1'b0;
    rd(3'd0, rv); chk("w1c_race", rv, 16'h0008);
    wr(3'd0, 16'h0008);
    rd(3'd0, rv); chk("w1c_clear", rv, 16'h0000);

    // FORCE with mask off, then unmask
    wr(3'd1, 16'h0000);
    wr(3'd4, 16'h0080);
    step();
    chk("frc_irq_masked", {15'd0, irq}, 16'd0);
    rd(3'd0, rv); chk("frc_pending", rv, 16'h0080);
    rd(3'd4, rv); chk("frc_read0", rv, 16'h0000);
    wr(3'd1, 16'h0080);
    chk("frc_irq_lat", {15'd0, irq}, 16'd0);
    step();
    chk("frc_irq", {15'd0, irq}, 16'd1);

    // Unused bits read 0 and are not writable
    wr(3'd1, 16'hFFFF);
    rd(3'd1, rv); chk("mask_width", rv, 16'h00FF);
    wr(3'd4, 16'hFF00);
    rd(3'd0, rv); chk("force_width", rv, 16'h0080);
    rd(3'd6, rv); chk("addr6", rv, 16'h0000);

`ifdef NIOS_SYSTEM_IRQ_CTRL_COALESCE_EN
    wr(3'd0, 16'h0080);
    bus.address = 3'd5; bus.chipselect = 1'b1;
    step();
    chk("co_irq_fall", {15'd0, irq}, 16'd0);
    for (int k = 0; k <= 10; k++) begin
      if (k == 1) irq_in[1] = 1'b1;
      if (k == 2) irq_in[1] = 1'b0;
      step();
      chk($sformatf("co_cnt_%0d", k), bus.readdata, 16'(10 - k));
      chk($sformatf("co_irq_%0d", k), {15'd0, irq}, (k == 10) ? 16'd1 : 16'd0);
    end
    bus.chipselect = 1'b0;
    wr(3'd0, 16'h0002);
    bus.address = 3'd5;
    step(); step(); step();
    chk("co_mid_cnt", bus.readdata, 16'd9);
    #2 reset_n = 1'b0;
    #1;
    chk("co_rst_irq", {15'd0, irq}, 16'd0);
    chk("co_rst_rd", bus.readdata, 16'd0);
    step();
    reset_n = 1'b1;
    rd(3'd5, rv); chk("co_rst_cnt", rv, 16'd0);
`else
    rd(3'd5, rv); chk("holdcnt_off", rv, 16'h0000);
    wr(3'd0, 16'h0080);
    step();
    wr(3'd4, 16'h0080);
    step();
    chk("no_holdoff_irq", {15'd0, irq}, 16'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
